imem_boot_ctrl: RTL and testbench
=================================

# imem_boot_ctrl

Boot/programming controller for the 16-word instruction memory of the single-cycle RV32 core. It owns the memory write port and the core reset: a byte stream from the host loader is packed into 32-bit little-endian words and written sequentially from address 0. The core is held in reset for the whole load and released only when the load completes. Outside a load session the core fetches freely from the current memory contents.

## Interface
Parameters:
- DEPTH, 16, instruction memory depth in words
- AW, 4, word address width; must equal $clog2(DEPTH)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- load_start  in  1  single-cycle request to begin a load session
- load_len  in  AW+1  number of words to load, sampled with load_start; 0 or values above DEPTH mean DEPTH
- rx_valid  in  1  host byte valid
- rx_data  in  8  host byte
- rx_ready  out  1  controller accepts a byte; handshake when rx_valid && rx_ready
- mem_we  out  1  instruction memory write strobe
- mem_waddr  out  AW  word write address
- mem_wdata  out  32  word write data
- cpu_rst  out  1  core reset, active-high
- busy  out  1  load session in progress
- done  out  1  single-cycle pulse: load completed successfully
- err  out  1  checksum failure latched; exists only when IMEM_CHECKSUM_EN is defined

## Operation
- States: RELEASE, RUN, LOAD, plus CHECK and ERR when IMEM_CHECKSUM_EN is defined.
- Reset: state=RELEASE. All registered outputs clear: mem_we=0, mem_waddr=0, mem_wdata=0, done=0, err=0. cpu_rst=1. Word count and byte index are 0.
- RELEASE: cpu_rst=1 and rx_ready=0. Unconditionally moves to RUN the next cycle.
- RUN: cpu_rst=0 and rx_ready=0. When load_start=1, captures the clamped length, clears the counters and the XOR accumulator, and moves to LOAD.
- LOAD: cpu_rst=1, busy=1, rx_ready=1.
  - Each accepted byte goes to lane byte_idx: byte 0 is bits [7:0], byte 3 is bits [31:24].
  - On the 4th byte, the next cycle has mem_we=1, mem_waddr=word_cnt and mem_wdata=the assembled word. word_cnt then increments and byte_idx wraps to 0.
  - When the last word's 4th byte is accepted, the state moves to RELEASE, or to CHECK when the macro is defined.
  - load_start is ignored while in LOAD.
- CHECK: rx_ready=1. Accepts one byte and compares it with the XOR of all loaded bytes.
  - Match: move to RELEASE.
  - Mismatch: move to ERR.
- ERR: cpu_rst=1, err=1, rx_ready=0. Only load_start leaves ERR; it clears err and enters LOAD.
- done pulses for exactly the first cycle of RELEASE that follows a completed session. It is not asserted on the post-reset RELEASE.
- Bytes offered outside LOAD/CHECK are not accepted (rx_ready=0). No state is affected.
- Memory locations beyond load_len keep their previous contents.

## Timing
- mem_we is registered and lags the 4th-byte handshake by 1 cycle.
- Back-to-back bytes at 1 byte/cycle are sustained, including during a mem_we cycle.
- The final mem_we coincides with the first cycle of RELEASE (or CHECK). cpu_rst is still 1 in that cycle.
- cpu_rst falls 2 cycles after the final handshake without the macro, or 2 cycles after the checksum handshake with it.
- rst asserted mid-session: immediate return to RELEASE and counters cleared. Partially written words stay in memory and the session is not resumed.
- load_start coincident with reset deassertion is ignored; load_start is honoured only in RUN and ERR.

## Configuration
- IMEM_CHECKSUM_EN defined:
  - A trailing XOR checksum byte is required after the data bytes.
  - The CHECK and ERR states and the err port exist.
  - A mismatch holds the core in reset indefinitely, until the next load.
- IMEM_CHECKSUM_EN undefined:
  - No checksum byte is expected, and no err port exists.
  - LOAD goes directly to RELEASE after the last word.

## Test plan
- Reset release: assert rst, then deassert → cpu_rst=1 for exactly one cycle (RELEASE), then 0; done stays 0; mem_we stays 0.
- Two-word load: load_len=2, bytes 13 00 00 00 B7 50 34 12 at one per cycle → mem_we at addr 0 with 0x00000013, then addr 1 with 0x123450B7; done pulses once; cpu_rst falls 2 cycles after the last byte.
- Stalled stream plus length clamp: load_len=0, rx_valid toggling randomly → exactly 16 writes at addresses 0..15 in order; byte lanes correct; busy=1 throughout.
- Checksum pass (macro defined): the two-word load followed by 0xD2 → done pulses, err=0. Checksum fail: followed by 0xD3 → err=1, cpu_rst stays 1, done=0; a new load_start clears err.
- Mid-load reset: rst asserted after 6 bytes → only address 0 was written; the state returns to RELEASE, then RUN; the next session starts at address 0.
- Ignored inputs: load_start during LOAD and rx_valid during RUN → no length recapture, rx_ready=0 in RUN, no writes.

Source files
------------

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: packs a host byte stream into imem words and holds the core in reset while loading; IMEM_CHECKSUM_EN adds a trailing XOR check byte
module imem_boot_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [AW:0]   load_len,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done
`ifdef IMEM_CHECKSUM_EN
  ,
  output logic          err
`endif
);
`ifdef IMEM_CHECKSUM_EN
  typedef enum logic [2:0] {RELEASE, RUN, LOAD, CHECK, ERR} state_t;
`else
  typedef enum logic [2:0] {RELEASE, RUN, LOAD} state_t;
`endif
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  state_t state_q, state_d;
  logic [AW:0] len_q, len_d, cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [23:0] word_q, word_d;
  logic we_q, we_d, done_q, done_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic hs, start;
`ifdef IMEM_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;
  logic err_q, err_d;
  assign busy = state_q == LOAD || state_q == CHECK;
  assign start = load_start && (state_q == RUN || state_q == ERR);
  assign err = err_q;
`else
  assign busy = state_q == LOAD;
  assign start = load_start && state_q == RUN;
`endif
  assign rx_ready = busy;
  assign hs = rx_valid && rx_ready;
  assign cpu_rst = state_q != RUN;
  assign mem_we = we_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign done = done_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RELEASE;
      len_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      word_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      xor_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      word_q <= word_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q <= done_d;
`ifdef IMEM_CHECKSUM_EN
      xor_q <= xor_d;
      err_q <= err_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    word_d = word_q;
    we_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d = 1'b0;
`ifdef IMEM_CHECKSUM_EN
    xor_d = xor_q;
    err_d = err_q;
`endif
    if (start) begin
      state_d = LOAD;
      len_d = (load_len == '0 || load_len > FULL) ? FULL : load_len;
      cnt_d = '0;
      idx_d = '0;
`ifdef IMEM_CHECKSUM_EN
      xor_d = '0;
      err_d = 1'b0;
`endif
    end else if (state_q == RELEASE) begin
      state_d = RUN;
    end else if (hs && state_q == LOAD) begin
      idx_d = idx_q + 2'd1;
      word_d = {idx_q == 2'd2 ? rx_data : word_q[23:16],
                idx_q == 2'd1 ? rx_data : word_q[15:8],
                idx_q == 2'd0 ? rx_data : word_q[7:0]};
`ifdef IMEM_CHECKSUM_EN
      xor_d = xor_q ^ rx_data;
`endif
      if (idx_q == 2'd3) begin
        we_d = 1'b1;
        waddr_d = cnt_q[AW-1:0];
        wdata_d = {rx_data, word_q};
        cnt_d = cnt_q + ONE;
        if (cnt_q + ONE == len_q) begin
`ifdef IMEM_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = RELEASE;
          done_d = 1'b1;
`endif
        end
      end
    end
`ifdef IMEM_CHECKSUM_EN
    else if (hs && state_q == CHECK) begin
      state_d = rx_data == xor_q ? RELEASE : ERR;
      done_d = rx_data == xor_q;
      err_d = rx_data != xor_q;
    end
`endif
  end
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl: scoreboard bench for word packing, reset handover, length clamp and ignored inputs
module tb_imem_boot_ctrl;
  localparam int AW = 4;
  logic clk = 1'b0, rst = 1'b1, load_start = 1'b0, rx_valid = 1'b0;
  logic [AW:0] load_len = '0;
  logic [7:0] rx_data = '0;
  logic rx_ready, mem_we, cpu_rst, busy, done;
  logic [AW-1:0] mem_waddr;
  logic [31:0] mem_wdata;
`ifdef IMEM_CHECKSUM_EN
  logic err;
`endif
  int vectors = 0, miscompares = 0, done_cnt = 0;
  bit busy_low = 1'b0;
  logic [35:0] exp_q[$];
  logic [35:0] exp_w;
  logic [31:0] words[16];
  logic [7:0] ck = '0;
  imem_boot_ctrl #(.DEPTH(16), .AW(AW)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done)
`ifdef IMEM_CHECKSUM_EN
    , .err(err)
`endif
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (!rst && mem_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL stray_write: addr=%0d data=%h, no write expected", mem_waddr, mem_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({mem_waddr, mem_wdata} !== exp_w) begin
          miscompares++;
          $display("FAIL write: got addr=%0d data=%h, want addr=%0d data=%h", mem_waddr, mem_wdata, exp_w[35:32], exp_w[31:0]);
        end
      end
    end
  end
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) begin
      vectors++;
      miscompares++;
      $display("FAIL rx_ready_timeout: rx_ready=%b after %0d cycles, want 1", rx_ready, n);
    end
    if (busy !== 1'b1) busy_low = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    ck = ck ^ b;
  endtask
  task automatic send_words(input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({4'(i), words[i]});
      for (int b = 0; b < 4; b++) begin
        if (stall) repeat ($urandom_range(0, 2)) @(negedge clk);
        send_byte(words[i][8*b +: 8]);
      end
    end
  endtask
  task automatic start_load(input logic [AW:0] len);
    load_start = 1'b1;
    load_len = len;
    @(negedge clk);
    load_start = 1'b0;
    ck = '0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({cpu_rst, mem_we, done, busy, rx_ready} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got cpu_rst,we,done,busy,ready=%b, want 10000", {cpu_rst, mem_we, done, busy, rx_ready});
    end
    vectors++;
    if ({mem_waddr, mem_wdata} !== 36'd0) begin
      miscompares++;
      $display("FAIL reset_bus: got addr=%0d data=%h, want 0/0", mem_waddr, mem_wdata);
    end
`ifdef IMEM_CHECKSUM_EN
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err: got %b, want 0", err);
    end
`endif
    rst = 1'b0;
    load_start = 1'b1;
    load_len = 5'd2;
    #1;
    vectors++;
    if (cpu_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL release_cycle: cpu_rst=%b, want 1", cpu_rst);
    end
    @(negedge clk);
    load_start = 1'b0;
    vectors++;
    if ({cpu_rst, busy, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL run_after_reset: got cpu_rst,busy,done=%b, want 000", {cpu_rst, busy, done});
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({cpu_rst, busy, done_cnt != 0} !== 3'b000) begin
      miscompares++;
      $display("FAIL run_steady: got cpu_rst=%b busy=%b done_cnt=%0d, want 0 0 0", cpu_rst, busy, done_cnt);
    end
  endtask
  task automatic test_two_word;
    int d0 = done_cnt;
    words[0] = 32'h00000013;
    words[1] = 32'h123450B7;
    start_load(5'd2);
    send_words(2, 1'b0);
`ifdef IMEM_CHECKSUM_EN
    vectors++;
    if ({cpu_rst, rx_ready, done} !== 3'b110) begin
      miscompares++;
      $display("FAIL check_state: got cpu_rst,ready,done=%b, want 110", {cpu_rst, rx_ready, done});
    end
    send_byte(ck);
`endif
    vectors++;
    if ({cpu_rst, done} !== 2'b11) begin
      miscompares++;
      $display("FAIL release_after_load: got cpu_rst,done=%b, want 11", {cpu_rst, done});
    end
    @(negedge clk);
    vectors++;
    if ({cpu_rst, done, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL cpu_rst_fall: got cpu_rst,done,busy=%b, want 000", {cpu_rst, done, busy});
    end
    vectors++;
    if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL two_word_end: got done pulses=%0d pending=%0d, want 1 0", done_cnt - d0, exp_q.size());
    end
  endtask
  task automatic test_clamp_stall;
    int d0 = done_cnt;
    for (int i = 0; i < 16; i++) words[i] = $urandom;
    start_load(5'd0);
    busy_low = 1'b0;
    send_words(16, 1'b1);
`ifdef IMEM_CHECKSUM_EN
    send_byte(ck);
`endif
    vectors++;
    if (busy_low !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_during_load: busy dropped=%b, want 0", busy_low);
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL clamp_done: got %b, want 1", done);
    end
    @(negedge clk);
    vectors++;
    if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL clamp_end: got done pulses=%0d pending=%0d, want 1 0", done_cnt - d0, exp_q.size());
    end
  endtask
  task automatic test_mid_reset;
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    start_load(5'd4);
    exp_q.push_back({4'd0, words[0]});
    for (int i = 0; i < 6; i++) send_byte(words[i / 4][8*(i % 4) +: 8]);
    rst = 1'b1;
    #1;
    vectors++;
    if ({cpu_rst, busy, rx_ready, mem_we} !== 4'b1000) begin
      miscompares++;
      $display("FAIL mid_reset: got cpu_rst,busy,ready,we=%b, want 1000", {cpu_rst, busy, rx_ready, mem_we});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (cpu_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_release: cpu_rst=%b, want 1", cpu_rst);
    end
    @(negedge clk);
    vectors++;
    if (cpu_rst !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mid_reset_run: got cpu_rst=%b pending=%0d, want 0 0", cpu_rst, exp_q.size());
    end
    words[0] = $urandom;
    start_load(5'd1);
    send_words(1, 1'b0);
`ifdef IMEM_CHECKSUM_EN
    send_byte(ck);
`endif
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0 || cpu_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_addr0: got pending=%0d cpu_rst=%b, want 0 0", exp_q.size(), cpu_rst);
    end
  endtask
  task automatic test_ignored;
    int d0;
    rx_valid = 1'b1;
    rx_data = 8'hAA;
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if ({rx_ready, cpu_rst, busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL run_ignores_rx: got ready,cpu_rst,busy=%b, want 000", {rx_ready, cpu_rst, busy});
      end
    end
    rx_valid = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 2; i++) words[i] = $urandom;
    start_load(5'd2);
    load_start = 1'b1;
    load_len = 5'd1;
    @(negedge clk);
    load_start = 1'b0;
    send_words(2, 1'b0);
`ifdef IMEM_CHECKSUM_EN
    send_byte(ck);
`endif
    @(negedge clk);
    vectors++;
    if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL no_recapture: got done pulses=%0d pending=%0d, want 1 0", done_cnt - d0, exp_q.size());
    end
  endtask
`ifdef IMEM_CHECKSUM_EN
  task automatic test_checksum_fail;
    int d0 = done_cnt;
    words[0] = 32'h00000013;
    words[1] = 32'h123450B7;
    start_load(5'd2);
    send_words(2, 1'b0);
    send_byte(ck ^ 8'h01);
    repeat (3) @(negedge clk);
    vectors++;
    if ({err, cpu_rst, rx_ready, done_cnt != d0} !== 4'b1100) begin
      miscompares++;
      $display("FAIL checksum_err: got err,cpu_rst,ready=%b done pulses=%0d, want 110 0", {err, cpu_rst, rx_ready}, done_cnt - d0);
    end
    start_load(5'd1);
    vectors++;
    if ({err, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL err_clear: got err,busy=%b, want 01", {err, busy});
    end
    words[0] = $urandom;
    send_words(1, 1'b0);
    send_byte(ck);
    vectors++;
    if ({done, err} !== 2'b10) begin
      miscompares++;
      $display("FAIL reload_ok: got done,err=%b, want 10", {done, err});
    end
    @(negedge clk);
  endtask
`endif
  initial begin
    test_reset;
    test_two_word;
    test_clamp_stall;
    test_mid_reset;
    test_ignored;
`ifdef IMEM_CHECKSUM_EN
    test_checksum_fail;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
